// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the ID/EX stage.
// The helper functions say which source registers an opcode actually reads.
package id_ex_hazard_stage_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write: 1'b0,
        memto_reg: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_src:   1'b0,
        branch:    1'b0,
        alu_op:    ALUOP_ADD
    };

    function automatic logic rs1_used(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic rs2_used(input logic [6:0] op);
        return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_ex_hazard_stage_hazard_detect_unit.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
// A taken branch overrides the stall because the ID instruction is being flushed.
module hazard_detect_unit
    import id_ex_hazard_stage_pkg::*;
(
    input  logic       mem_read_ex_i,
    input  logic       valid_ex_i,
    input  logic [4:0] rd_ex_i,
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    input  logic [6:0] opcode_id_i,
    input  logic       pcsrc_i,
    output logic       stall_o,
    output logic       pc_write_o,
    output logic       if_id_write_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic hazard;

    assign rs1_hit = rs1_used(opcode_id_i) && (rd_ex_i == rs1_id_i);
    assign rs2_hit = rs2_used(opcode_id_i) && (rd_ex_i == rs2_id_i);

    assign hazard = mem_read_ex_i && valid_ex_i && (rd_ex_i != 5'd0)
                 && (rs1_hit || rs2_hit);

    assign stall_o       = hazard && !pcsrc_i;
    assign pc_write_o    = !stall_o;
    assign if_id_write_o = !stall_o;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles, WB bypass
// and saturating stall/flush counters.
module id_ex_hazard_stage
    import id_ex_hazard_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  PC_ID,
    input  logic [XLEN-1:0]  REG_DATA1_ID,
    input  logic [XLEN-1:0]  REG_DATA2_ID,
    input  logic [XLEN-1:0]  IMM_ID,
    input  logic [2:0]       FUNCT3_ID,
    input  logic [6:0]       FUNCT7_ID,
    input  logic [6:0]       OPCODE,
    input  logic [4:0]       RD_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             RegWrite_ID,
    input  logic             MemtoReg_ID,
    input  logic             MemRead_ID,
    input  logic             MemWrite_ID,
    input  logic             ALUSrc_ID,
    input  logic             Branch_ID,
    input  logic [1:0]       ALUop_ID,
    input  logic             PCSrc,
    input  logic             RegWrite_WB,
    input  logic [4:0]       RD_WB,
    input  logic [XLEN-1:0]  ALU_DATA_WB,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic [XLEN-1:0]  PC_EX,
    output logic [XLEN-1:0]  REG_DATA1_EX,
    output logic [XLEN-1:0]  REG_DATA2_EX,
    output logic [XLEN-1:0]  IMM_EX,
    output logic [2:0]       FUNCT3_EX,
    output logic [6:0]       FUNCT7_EX,
    output logic [6:0]       OPCODE_EX,
    output logic [4:0]       RD_EX,
    output logic [4:0]       RS1_EX,
    output logic [4:0]       RS2_EX,
    output logic             RegWrite_EX,
    output logic             MemtoReg_EX,
    output logic             MemRead_EX,
    output logic             MemWrite_EX,
    output logic             ALUSrc_EX,
    output logic             Branch_EX,
    output logic [1:0]       ALUop_EX,
    output logic             VALID_EX,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    logic [XLEN-1:0]  pc_q, rd1_q, rd2_q, imm_q;
    logic [XLEN-1:0]  rd1_d, rd2_d;
    logic [2:0]       f3_q;
    logic [6:0]       f7_q, op_q;
    logic [4:0]       rd_q, rs1_q, rs2_q;
    ctrl_t            ctrl_q, ctrl_id;
    logic             valid_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall;
    logic             fwd1, fwd2;

    hazard_detect_unit u_hdu (
        .mem_read_ex_i (ctrl_q.mem_read),
        .valid_ex_i    (valid_q),
        .rd_ex_i       (rd_q),
        .rs1_id_i      (RS1_ID),
        .rs2_id_i      (RS2_ID),
        .opcode_id_i   (OPCODE),
        .pcsrc_i       (PCSrc),
        .stall_o       (stall),
        .pc_write_o    (PC_write),
        .if_id_write_o (IF_ID_write)
    );

    assign ctrl_id = '{
        reg_write: RegWrite_ID,
        memto_reg: MemtoReg_ID,
        mem_read:  MemRead_ID,
        mem_write: MemWrite_ID,
        alu_src:   ALUSrc_ID,
        branch:    Branch_ID,
        alu_op:    ALUop_ID
    };

    // The register file is read before WB writes it, so same-cycle WB data wins.
    assign fwd1 = WB_BYPASS && RegWrite_WB && (RD_WB != 5'd0)
               && (RD_WB == RS1_ID);
    assign fwd2 = WB_BYPASS && RegWrite_WB && (RD_WB != 5'd0)
               && (RD_WB == RS2_ID);

    assign rd1_d = fwd1 ? ALU_DATA_WB : REG_DATA1_ID;
    assign rd2_d = fwd2 ? ALU_DATA_WB : REG_DATA2_ID;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            f3_q        <= '0;
            f7_q        <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            ctrl_q      <= CTRL_BUBBLE;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q  <= PC_ID;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            imm_q <= IMM_ID;
            f3_q  <= FUNCT3_ID;
            f7_q  <= FUNCT7_ID;
            op_q  <= OPCODE;
            rd_q  <= RD_ID;
            rs1_q <= RS1_ID;
            rs2_q <= RS2_ID;
            if (PCSrc) begin
                ctrl_q  <= CTRL_BUBBLE;
                valid_q <= 1'b0;
                if (flush_cnt_q != '1)
                    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else if (stall) begin
                ctrl_q  <= CTRL_BUBBLE;
                valid_q <= 1'b0;
                if (stall_cnt_q != '1)
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end else begin
                ctrl_q  <= ctrl_id;
                valid_q <= 1'b1;
            end
        end
    end

    assign PC_EX        = pc_q;
    assign REG_DATA1_EX = rd1_q;
    assign REG_DATA2_EX = rd2_q;
    assign IMM_EX       = imm_q;
    assign FUNCT3_EX    = f3_q;
    assign FUNCT7_EX    = f7_q;
    assign OPCODE_EX    = op_q;
    assign RD_EX        = rd_q;
    assign RS1_EX       = rs1_q;
    assign RS2_EX       = rs2_q;
    assign RegWrite_EX  = ctrl_q.reg_write;
    assign MemtoReg_EX  = ctrl_q.memto_reg;
    assign MemRead_EX   = ctrl_q.mem_read;
    assign MemWrite_EX  = ctrl_q.mem_write;
    assign ALUSrc_EX    = ctrl_q.alu_src;
    assign Branch_EX    = ctrl_q.branch;
    assign ALUop_EX     = ctrl_q.alu_op;
    assign VALID_EX     = valid_q;
    assign STALL_CNT    = stall_cnt_q;
    assign FLUSH_CNT    = flush_cnt_q;

endmodule
